// File: rtl/alu_pkg.sv
// Shared op encodings, compare-flag indices, FSM states and op-class helpers for alu_muldiv.
package alu_pkg;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_t;

  localparam int CMP_EQ  = 0;
  localparam int CMP_NE  = 1;
  localparam int CMP_LT  = 2;
  localparam int CMP_GE  = 3;
  localparam int CMP_LTU = 4;
  localparam int CMP_GEU = 5;
  localparam int CMP_W   = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2
  } alu_state_t;

  function automatic logic is_mul(input alu_op_t o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_MULHU);
  endfunction

  function automatic logic is_div(input alu_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative radix-2 restoring divider: first step taken on start, WIDTH steps total, then done
// is raised for one cycle with the sign-corrected quotient or remainder on result.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             kill,
  input  logic             signed_op,
  input  logic             want_rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             rem_sel_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [2*WIDTH-1:0] first_step;
  logic [2*WIDTH-1:0] next_step;

  // One restoring step: shift the next dividend bit into the partial remainder and subtract if it fits.
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] r,
                                              input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] d);
    logic [WIDTH:0] diff;
    diff = {r, q[WIDTH-1]} - {1'b0, d};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    else              return {r[WIDTH-2:0], q[WIDTH-1], q[WIDTH-2:0], 1'b0};
  endfunction

  assign a_neg      = signed_op & dividend[WIDTH-1];
  assign b_neg      = signed_op & divisor[WIDTH-1];
  assign a_mag      = a_neg ? -dividend : dividend;
  assign b_mag      = b_neg ? -divisor  : divisor;
  assign first_step = step({WIDTH{1'b0}}, a_mag, b_mag);
  assign next_step  = step(rem_q, quo_q, dvs_q);

  assign done   = busy && (cnt == LAST);
  assign result = rem_sel_q ? (rneg_q ? -rem_q : rem_q)
                            : (qneg_q ? -quo_q : quo_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      rem_sel_q <= 1'b0;
    end else if (kill) begin
      busy <= 1'b0;
    end else if (start) begin
      busy           <= 1'b1;
      cnt            <= CW'(1);
      {rem_q, quo_q} <= first_step;
      dvs_q          <= b_mag;
      qneg_q         <= a_neg ^ b_neg;
      rneg_q         <= a_neg;
      rem_sel_q      <= want_rem;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        {rem_q, quo_q} <= next_step;
        cnt            <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// RV32I/M execute ALU: single-cycle ops in 1 cycle, multiplies via a short pipeline, divides
// via the iterative divider; issue stalls (in_ready low) while a multi-cycle op is in flight.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2,
  parameter int OP_W        = ALU_OP_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [OP_W-1:0]  op,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [WIDTH-1:0] imm,
  output logic [5:0]       compare_async,
  output logic             out_valid,
  output logic [WIDTH-1:0] eval
);

  localparam int  SHW        = $clog2(WIDTH);
  localparam int  MUL_STAGES = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
  localparam bit  MUL_FAST   = (MUL_LATENCY == 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_t state, next_state;
  alu_op_t    op_e;

  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sub_res;
  logic             lt, ltu, eq;
  logic             accept;
  logic             is_m, is_d, fast_done;
  logic             div_signed, div_rem, div_zero, div_ovf, div_special;
  logic [WIDTH-1:0] special_res, alu_res, mul_res, fast_res;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic             a_sgn, b_sgn;

  logic [WIDTH-1:0] mul_pipe [MUL_STAGES];
  logic [MUL_STAGES-1:0] mul_vld;
  logic             mul_done;
  logic             div_done;
  logic [WIDTH-1:0] div_result;

  assign op_e = alu_op_t'(op);
  assign opb  = use_imm ? imm : rs2_val;

  // Sign-extended WIDTH+1 subtraction keeps lt correct when rs1-opb overflows.
  assign {lt, sub_res} = {rs1_val[WIDTH-1], rs1_val} - {opb[WIDTH-1], opb};
  assign ltu = rs1_val < opb;
  assign eq  = rs1_val == opb;

  assign compare_async[CMP_EQ]  = eq;
  assign compare_async[CMP_NE]  = ~eq;
  assign compare_async[CMP_LT]  = lt;
  assign compare_async[CMP_GE]  = ~lt;
  assign compare_async[CMP_LTU] = ltu;
  assign compare_async[CMP_GEU] = ~ltu;

  assign accept = in_valid & in_ready & ~flush;
  assign is_m   = is_mul(op_e);
  assign is_d   = is_div(op_e);

  assign div_signed  = (op_e == OP_DIV) || (op_e == OP_REM);
  assign div_rem     = (op_e == OP_REM) || (op_e == OP_REMU);
  assign div_zero    = (opb == '0);
  assign div_ovf     = div_signed && (rs1_val == MIN_VAL) && (opb == '1);
  assign div_special = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = div_rem ? rs1_val : '1;
    else if (div_ovf) special_res = div_rem ? '0 : MIN_VAL;
  end

  assign a_sgn   = (op_e == OP_MULH) || (op_e == OP_MULHSU);
  assign b_sgn   = (op_e == OP_MULH);
  assign a_ext   = {{WIDTH{a_sgn & rs1_val[WIDTH-1]}}, rs1_val};
  assign b_ext   = {{WIDTH{b_sgn & opb[WIDTH-1]}}, opb};
  assign product = a_ext * b_ext;
  assign mul_res = (op_e == OP_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];

  always_comb begin
    alu_res = '0;
    case (op_e)
      OP_ADD:  alu_res = rs1_val + opb;
      OP_SUB:  alu_res = sub_res;
      OP_SLL:  alu_res = rs1_val << opb[SHW-1:0];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ltu};
      OP_XOR:  alu_res = rs1_val ^ opb;
      OP_SRL:  alu_res = rs1_val >> opb[SHW-1:0];
      OP_SRA:  alu_res = $signed(rs1_val) >>> opb[SHW-1:0];
      OP_OR:   alu_res = rs1_val | opb;
      OP_AND:  alu_res = rs1_val & opb;
      default: alu_res = '0;
    endcase
  end

  assign fast_res  = is_d ? special_res : (is_m ? mul_res : alu_res);
  assign fast_done = (!is_d && !is_m) || (is_d && div_special) || (is_m && MUL_FAST);
  assign mul_done  = mul_vld[MUL_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = (state == IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_m && !MUL_FAST)       next_state = MUL_WAIT;
          else if (is_d && !div_special) next_state = DIV_RUN;
        end
      end
      MUL_WAIT: if (flush || mul_done) next_state = IDLE;
      DIV_RUN:  if (flush || div_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mul_vld <= '0;
      for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
    end else begin
      if (flush) mul_vld <= '0;
      else begin
        mul_vld[0] <= accept && is_m && !MUL_FAST;
        for (int i = 1; i < MUL_STAGES; i++) mul_vld[i] <= mul_vld[i-1];
      end
      if (accept && is_m) mul_pipe[0] <= mul_res;
      for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      eval      <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (accept && fast_done) begin
          eval      <= fast_res;
          out_valid <= 1'b1;
        end
        MUL_WAIT: if (!flush && mul_done) begin
          eval      <= mul_pipe[MUL_STAGES-1];
          out_valid <= 1'b1;
        end
        DIV_RUN: if (!flush && div_done) begin
          eval      <= div_result;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (accept && is_d && !div_special),
    .kill      (flush),
    .signed_op (div_signed),
    .want_rem  (div_rem),
    .dividend  (rs1_val),
    .divisor   (opb),
    .done      (div_done),
    .result    (div_result)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32, MUL_LATENCY=2 with hand-computed expectations.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         use_imm = 1'b0;
  logic [4:0]   op = 5'd0;
  logic [W-1:0] rs1_val = '0;
  logic [W-1:0] rs2_val = '0;
  logic [W-1:0] imm = '0;
  logic         in_ready;
  logic         out_valid;
  logic [5:0]   compare_async;
  logic [W-1:0] eval;

  int errors = 0;
  int checks = 0;

  alu_muldiv #(.WIDTH(W), .MUL_LATENCY(2), .OP_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .op(op), .use_imm(use_imm), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .compare_async(compare_async), .out_valid(out_valid), .eval(eval)
  );

  always #5 clock = ~clock;

  alu_op_t      al_op  [8] = '{OP_SRL, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SLT};
  logic [W-1:0] al_a   [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                               32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000001, 32'h80000000};
  logic [W-1:0] al_b   [8] = '{32'd4, 32'd1, 32'd1, 32'hFF00FF00, 32'h0000000F, 32'hFF00FF00,
                               32'd35, 32'd1};
  logic [W-1:0] al_exp [8] = '{32'h08000000, 32'd1, 32'd0, 32'h0FF00FF0, 32'hF0F0F0FF,
                               32'hF000F000, 32'd8, 32'd1};

  alu_op_t      mu_op  [4] = '{OP_MULH, OP_MULHU, OP_MUL, OP_MULHSU};
  logic [W-1:0] mu_a   [4] = '{32'h80000000, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF};
  logic [W-1:0] mu_b   [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd2};
  logic [W-1:0] mu_exp [4] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFA, 32'hFFFFFFFF};

  alu_op_t      dv_op  [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
  logic [W-1:0] dv_a   [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
  logic [W-1:0] dv_b   [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
  logic [W-1:0] dv_exp [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};

  alu_op_t      sp_op  [6] = '{OP_DIVU, OP_REMU, OP_REM, OP_DIV, OP_DIV, OP_REM};
  logic [W-1:0] sp_a   [6] = '{32'd100, 32'd100, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB};
  logic [W-1:0] sp_b   [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
  logic [W-1:0] sp_exp [6] = '{32'hFFFFFFFF, 32'd100, 32'd0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFB};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input alu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    op       = o;
    rs1_val  = a;
    rs2_val  = b;
    use_imm  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (eval !== 32'd0) begin errors++; $display("FAIL reset_eval got=%h want=00000000", eval); end
    reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_v [3] = '{32'd12, 32'hFFFFFFFE, 32'hF8000000};
    drive(OP_ADD, 32'd5, 32'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) drive(OP_SUB, 32'd3, 32'd5);
      else if (i == 1) drive(OP_SRA, 32'h80000000, 32'd4);
      else in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_valid[%0d] got=%b/%b want=1/1", i, out_valid, in_ready);
      end
      checks++;
      if (eval !== exp_v[i]) begin errors++; $display("FAIL b2b_eval[%0d] got=%h want=%h", i, eval, exp_v[i]); end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || eval !== 32'hF8000000) begin
      errors++; $display("FAIL b2b_hold got=%b/%h want=0/f8000000", out_valid, eval);
    end
  endtask

  task automatic test_alu_ops();
    for (int i = 0; i < 8; i++) begin
      drive(al_op[i], al_a[i], al_b[i]);
      tick();
      checks++;
      if (out_valid !== 1'b1 || eval !== al_exp[i]) begin
        errors++; $display("FAIL alu_op[%0d] got=%b/%h want=1/%h", i, out_valid, eval, al_exp[i]);
      end
    end
    drive(OP_ADD, 32'd10, 32'd999);
    use_imm = 1'b1;
    imm     = 32'hFFFFFFFD;
    tick();
    in_valid = 1'b0;
    use_imm  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || eval !== 32'd7) begin
      errors++; $display("FAIL alu_imm got=%b/%h want=1/00000007", out_valid, eval);
    end
  endtask

  task automatic test_compare();
    logic [W-1:0] ca [5] = '{32'hFFFFFFFF, 32'h80000000, 32'd1, 32'd3, 32'h7FFFFFFF};
    logic [W-1:0] cb [5] = '{32'd1, 32'd1, 32'h80000000, 32'd3, 32'hFFFFFFFF};
    logic [5:0]   ce [5] = '{6'b100110, 6'b100110, 6'b011010, 6'b101001, 6'b011010};
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rs1_val = ca[i];
      if (i == 3) begin use_imm = 1'b1; imm = cb[i]; rs2_val = 32'd100; end
      else begin use_imm = 1'b0; rs2_val = cb[i]; end
      #1;
      checks++;
      if (compare_async !== ce[i]) begin
        errors++; $display("FAIL compare[%0d] got=%b want=%b", i, compare_async, ce[i]);
      end
    end
    use_imm = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    for (int i = 0; i < 4; i++) begin
      drive(mu_op[i], mu_a[i], mu_b[i]);
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL mul_busy[%0d] got=%b/%b want=0/0", i, in_ready, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || eval !== mu_exp[i]) begin
        errors++; $display("FAIL mul_res[%0d] got=%b/%b/%h want=1/1/%h", i, out_valid, in_ready, eval, mu_exp[i]);
      end
    end
  endtask

  task automatic test_div();
    int n;
    int ready_hi;
    drive(dv_op[0], dv_a[0], dv_b[0]);
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(dv_op[i+1], dv_a[i+1], dv_b[i+1]);
      else in_valid = 1'b0;
      n = 1;
      ready_hi = 0;
      while (!out_valid && n < 100) begin
        if (in_ready) ready_hi++;
        tick();
        n++;
      end
      checks++;
      if (n != 33 || ready_hi != 0) begin
        errors++; $display("FAIL div_timing[%0d] got=%0d/%0d want=33/0", i, n, ready_hi);
      end
      checks++;
      if (eval !== dv_exp[i] || in_ready !== 1'b1) begin
        errors++; $display("FAIL div_res[%0d] got=%h/%b want=%h/1", i, eval, in_ready, dv_exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_div_special();
    for (int i = 0; i < 6; i++) begin
      drive(sp_op[i], sp_a[i], sp_b[i]);
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || eval !== sp_exp[i]) begin
        errors++; $display("FAIL div_special[%0d] got=%b/%b/%h want=1/1/%h", i, out_valid, in_ready, eval, sp_exp[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int pulses;
    drive(OP_ADD, 32'd1, 32'd1);
    tick();
    drive(OP_ADD, 32'd2, 32'd2);
    flush = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || eval !== 32'd2) begin
      errors++; $display("FAIL flush_idle_pulse got=%b/%h want=1/00000002", out_valid, eval);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || eval !== 32'd2) begin
      errors++; $display("FAIL flush_idle_block got=%b/%h want=0/00000002", out_valid, eval);
    end
    drive(OP_MUL, 32'd5, 32'd5);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0 || in_ready !== 1'b1 || eval !== 32'd2) begin
      errors++; $display("FAIL flush_mul got=%0d/%b/%h want=0/1/00000002", pulses, in_ready, eval);
    end
    drive(OP_DIV, 32'd100, 32'd7);
    tick();
    in_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      if (out_valid) pulses++;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || eval !== 32'd2) begin
      errors++; $display("FAIL flush_div_idle got=%b/%b/%h want=1/0/00000002", in_ready, out_valid, eval);
    end
    for (int k = 0; k < 40; k++) begin
      if (out_valid) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0 || eval !== 32'd2) begin
      errors++; $display("FAIL flush_div_quiet got=%0d/%h want=0/00000002", pulses, eval);
    end
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    drive(OP_DIV, 32'd100, 32'd7);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (eval !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_div got=%h/%b/%b want=00000000/0/1", eval, out_valid, in_ready);
    end
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0 || eval !== 32'd0) begin
      errors++; $display("FAIL reset_mid_div_quiet got=%0d/%h want=0/00000000", pulses, eval);
    end
    drive(OP_ADD, 32'd2, 32'd3);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || eval !== 32'd5) begin
      errors++; $display("FAIL reset_recover got=%b/%h want=1/00000005", out_valid, eval);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alu_ops();
    test_compare();
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor of the stage-3 execute ALU.
- Covers the full RV32I/M integer op set at configurable WIDTH, with registered result and combinational branch-compare flags.
- Single-cycle ops complete in 1 cycle; multiplies use a MUL_LATENCY-deep pipeline; divides/remainders use an iterative radix-2 divider.
- A valid/ready/flush handshake stalls issue while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32: operand/result width, power of two, >=8.
- MUL_LATENCY, 2: cycles from accept to out_valid for MUL* ops, >=1.
- OP_W, 5: width of op encoding.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  combinational; high iff FSM in IDLE
- flush  in  1  abort in-flight op, discard result; blocks accept this cycle
- op  in  OP_W  alu_pkg::alu_op_t
- use_imm  in  1  1: second operand = imm, 0: rs2_val
- rs1_val  in  WIDTH  operand A
- rs2_val  in  WIDTH  operand B (register)
- imm  in  WIDTH  operand B (immediate, already sign-extended)
- compare_async  out  6  combinational flags {geu,ltu,ge,lt,ne,eq} of rs1_val vs selected operand B
- out_valid  out  1  one-cycle pulse, eval updated
- eval  out  WIDTH  registered result, holds between pulses

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, out_valid=0, eval=0, divider/mul pipeline cleared.
  - in_ready=1 once reset_n is high.
- Accept condition: in_valid & in_ready & ~flush at a rising edge. Operands and op are latched at accept.
- Ops and latency (accept in cycle c):
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: out_valid in c+1; FSM stays IDLE, back-to-back issue every cycle.
  - MUL, MULH, MULHSU, MULHU: state MUL_WAIT; out_valid in c+MUL_LATENCY. MUL returns low WIDTH bits; others return high WIDTH bits of the 2*WIDTH product with RISC-V signedness.
  - DIV, DIVU, REM, REMU: state DIV_RUN; WIDTH iteration cycles, then sign fix-up; out_valid in c+WIDTH+1.
- Shift amount: low log2(WIDTH) bits of operand B. SRA sign-fills. SLT/SLTU write 1 or 0.
- Special divides complete in c+1 with no DIV_RUN:
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- FSM: IDLE -> MUL_WAIT | DIV_RUN on accept of a multi-cycle op. Busy state -> IDLE on the completion edge, which also sets out_valid. A new op may be accepted in the cycle out_valid is high.
- flush:
  - In a busy state: return to IDLE next edge, no out_valid, eval unchanged.
  - In IDLE: only suppresses accept. A single-cycle result already registered still pulses.
- compare_async is purely combinational and independent of FSM state.
  - lt is signed, computed from a WIDTH+1 subtraction (not sub bit[WIDTH-1]), so it is correct on overflow.
- No output backpressure: the consumer must take eval on out_valid.
- reset_n asserted mid-divide or mid-multiply: immediate return to reset state, no output.

Decomposition:
- alu_pkg:
  - alu_op_t enum (18 codes).
  - Compare index constants CMP_EQ..CMP_GEU.
  - alu_state_t {IDLE, MUL_WAIT, DIV_RUN}.
  - is_mul/is_div helper functions.
- Sub-module alu_divider: iterative restoring divider.
  - Ports: clock, reset_n, start, kill, signed_op, want_rem, dividend, divisor, done, result.
  - WIDTH-cycle counter, remainder/quotient shift registers, sign fix-up.
- Multiplier is an inline product register plus a MUL_LATENCY-1 delay line.

Test Plan (WIDTH=32, MUL_LATENCY=2):
1. Reset pulse, then ADD 5+7, SUB 3-5, SRA 0x80000000>>>4 on consecutive cycles -> out_valid three consecutive cycles; eval = 12, 0xFFFFFFFE, 0xF8000000.
2. Compare rs1=0xFFFFFFFF, rs2=1 -> lt=1, ge=0, ltu=0, geu=1, ne=1; rs1=0x80000000, rs2=1 -> lt=1 (overflow case).
3. MULH 0x80000000 * 0x80000000 -> in_ready low 1 cycle, out_valid at c+2, eval = 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
4. DIV -7/2 -> eval 0xFFFFFFFD at c+33; REM -7/2 -> 0xFFFFFFFF; in_ready low c+1..c+32; op held at in_valid not accepted until then.
5. DIVU 100/0 -> 0xFFFFFFFF at c+1; REM 0x80000000 / 0xFFFFFFFF -> 0; DIV same -> 0x80000000, both at c+1.
6. DIV started, flush at c+10 -> no out_valid, IDLE at c+11, eval unchanged. Repeat with reset_n low at c+5 -> eval=0, out_valid=0.
